// File: rtl/blur_pkg.sv
// -----------------------------------------------------------------------------
// blur_pkg
// Shared constants and types for the 5x5 blur window controller.
//   DSIZE   : bits per colour channel
//   PIX_W   : bits per RGB pixel (R in the MSBs)
//   WIN_DIM : window edge length in pixels
//   WIN_N   : pixels per window
//   state_e : controller frame-sequencing states
// -----------------------------------------------------------------------------
package blur_pkg;

  localparam int DSIZE   = 5;
  localparam int PIX_W   = 3 * DSIZE;
  localparam int WIN_DIM = 5;
  localparam int WIN_N   = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// Fixed-depth shift register holding one image row. It advances only when
// enabled, so the tap is always exactly DEPTH enabled shifts old.
// Contents are deliberately not reset.
// Ports:
//   i_clk  : clock
//   i_en   : shift enable (one pixel accepted)
//   i_data : pixel shifted in
//   o_tap  : oldest stored pixel
// -----------------------------------------------------------------------------
module line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = blur_pkg::PIX_W
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_tap
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      mem_q[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign o_tap = mem_q[DEPTH-1];

endmodule

// File: rtl/blur_window_ctrl.sv
// -----------------------------------------------------------------------------
// blur_window_ctrl
// Accepts a raster-order frame of RGB pixels and presents a sliding 5x5
// window to a blur datapath with one register of latency. Four row-deep line
// buffers supply the four older rows of each new window column.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : frame start pulse (only honoured when idle)
//   i_valid        : input pixel valid
//   i_pixel        : raster-order input pixel
//   o_ready        : pixel accepted when i_valid && o_ready (RUN only)
//   o_window       : 5x5 window, index 0 (top-left) in the MSBs, column-major
//   o_win_valid    : o_window holds a complete in-frame window
//   o_blur_valid   : blur datapath output valid (o_win_valid delayed)
//   o_x, o_y       : window-centre coordinate aligned with o_blur_valid
//   o_busy         : controller not idle
//   o_done         : one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module blur_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48,
  parameter int DSIZE = blur_pkg::DSIZE
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_start,
  input  logic                                 i_valid,
  input  logic [3*DSIZE-1:0]                   i_pixel,
  output logic                                 o_ready,
  output logic [blur_pkg::WIN_N*3*DSIZE-1:0]   o_window,
  output logic                                 o_win_valid,
  output logic                                 o_blur_valid,
  output logic [$clog2(IMG_W)-1:0]             o_x,
  output logic [$clog2(IMG_H)-1:0]             o_y,
  output logic                                 o_busy,
  output logic                                 o_done
);

  import blur_pkg::*;

  localparam int PW    = 3 * DSIZE;
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int WW    = WIN_N * PW;
  localparam int COL_W = WIN_DIM * PW;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          drain_q, drain_d;

  logic          accept;
  logic          x_wrap;
  logic          last_px;
  logic          win_ok;

  logic [PW-1:0] lb_in [4];
  logic [PW-1:0] tap   [4];

  logic [WW-1:0] win_q;
  logic          win_valid_q;
  logic          blur_valid_q;
  logic [XW-1:0] cx_q, ox_q;
  logic [YW-1:0] cy_q, oy_q;

  assign accept  = i_valid && (state_q == RUN);
  assign x_wrap  = (x_q == XW'(IMG_W - 1));
  assign last_px = x_wrap && (y_q == YW'(IMG_H - 1));
  // Only accepts with four full rows and columns behind them complete a
  // window, which also keeps stale line-buffer data out of valid windows.
  assign win_ok  = (x_q >= XW'(4)) && (y_q >= YW'(4));

  // lb0 takes the live pixel; each deeper buffer takes the previous tap.
  assign lb_in[0] = i_pixel;
  assign lb_in[1] = tap[0];
  assign lb_in[2] = tap[1];
  assign lb_in[3] = tap[2];

  for (genvar g = 0; g < 4; g++) begin : g_lb
    line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (PW)
    ) u_lb (
      .i_clk  (i_clk),
      .i_en   (accept),
      .i_data (lb_in[g]),
      .o_tap  (tap[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (x_wrap) begin
            x_d = '0;
            y_d = last_px ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (last_px) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      // Two drain cycles let the final window and blur result flush out.
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Window shifts one column left per accept; the new right column is
  // ordered top (four rows old) to bottom (live pixel).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      blur_valid_q <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
    end else begin
      win_valid_q  <= accept && win_ok;
      blur_valid_q <= win_valid_q;
      if (accept) begin
        win_q <= {win_q[WW-COL_W-1:0], tap[3], tap[2], tap[1], tap[0], i_pixel};
      end
      if (accept && win_ok) begin
        cx_q <= x_q - XW'(2);
        cy_q <= y_q - YW'(2);
      end
      if (win_valid_q) begin
        ox_q <= cx_q;
        oy_q <= cy_q;
      end
    end
  end

  assign o_ready      = (state_q == RUN);
  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == DONE);
  assign o_window     = win_q;
  assign o_win_valid  = win_valid_q;
  assign o_blur_valid = blur_valid_q;
  assign o_x          = ox_q;
  assign o_y          = oy_q;

endmodule

// File: doc/blur_window_ctrl.md
BLUR_WINDOW_CTRL -- requirements
Module: blur_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 64, pixels per row (>=5).
REQ-002 SHALL have parameter IMG_H, default 48, rows per frame (>=5).
REQ-003 SHALL have parameter DSIZE, default 5, bits per colour channel; pixel width is 3*DSIZE (R,G,B, with R in the MSBs).
REQ-004 i_clk  in  1  clock; reset i_rst_n, asynchronous, active-low; clock i_clk.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_start  in  1  frame start pulse; honoured only in IDLE.
REQ-007 i_valid  in  1  input pixel valid.
REQ-008 i_pixel  in  3*DSIZE  raster-order input pixel.
REQ-009 o_ready  out  1  input pixel accepted when i_valid && o_ready.
REQ-010 o_window  out  75*DSIZE  5x5 window to the blur datapath; index 0 (oldest, top-left) in the MSBs, column-major, index 24 (newest, bottom-right) in the LSBs.
REQ-011 o_win_valid  out  1  o_window holds a complete in-frame window.
REQ-012 o_blur_valid  out  1  blur datapath output valid; o_win_valid delayed one cycle.
REQ-013 o_x / o_y  out  clog2(IMG_W) / clog2(IMG_H)  window-centre coordinate, aligned with o_blur_valid.
REQ-014 o_busy  out  1  high in every state except IDLE.
REQ-015 o_done  out  1  one-cycle end-of-frame pulse.

Function
REQ-016 States: IDLE, RUN, DRAIN, DONE; IDLE->RUN on i_start, with column and row counters cleared.
REQ-017 o_ready SHALL equal 1 only in RUN; i_valid outside RUN is ignored, including i_valid coincident with i_start.
REQ-018 Each accept SHALL shift the window one column left and insert a new right column, top to bottom: {lb3 tap, lb2 tap, lb1 tap, lb0 tap, i_pixel}.
REQ-019 Line buffers lb0..lb3 are IMG_W-deep shift registers that advance only on accept; lb0 takes i_pixel and lbN takes the lb(N-1) tap, so each tap is exactly IMG_W accepts old.
REQ-020 Column counter x SHALL increment on accept and wrap IMG_W-1->0, incrementing row counter y.
REQ-021 o_win_valid SHALL be registered high in the cycle after an accept at (x,y) with x>=4 and y>=4, and low otherwise (including input gaps).
REQ-022 When o_win_valid is high, o_window SHALL cover rows y-4..y and columns x-4..x of that accept.
REQ-023 o_window SHALL hold its value on non-accept cycles.
REQ-024 o_blur_valid, o_x=x-2 and o_y=y-2 SHALL be registered one cycle after the corresponding o_win_valid, matching the blur datapath's one-register latency.
REQ-025 Valid outputs per frame SHALL be exactly (IMG_W-4)*(IMG_H-4); border pixels produce no output.
REQ-026 Accept of (IMG_W-1, IMG_H-1) at cycle T SHALL move RUN->DRAIN, with o_ready low from T+1.
REQ-027 DRAIN SHALL last 2 cycles, then DONE for 1 cycle with o_done=1 (cycle T+3, after the final o_blur_valid at T+2), then IDLE.
REQ-028 i_start in RUN, DRAIN or DONE SHALL be ignored.
REQ-029 Counter widths are clog2 of the dimension; no arithmetic overflow is permitted.

Reset
REQ-030 On i_rst_n low: state IDLE; x, y, window register and all outputs 0 (o_ready, o_win_valid, o_blur_valid, o_busy, o_done, o_x, o_y, o_window).
REQ-031 Line-buffer contents are not reset; stale data SHALL never reach a valid window.
REQ-032 Reset mid-frame SHALL abort immediately; the next i_start begins a clean frame.

Structure
REQ-033 Package blur_pkg SHALL hold DSIZE, PIX_W=3*DSIZE, WIN_N=25 and the state enum typedef.
REQ-034 One sub-module, line_buffer (parameters depth and width; ports i_clk, shift enable, data in, tap out), SHALL be instantiated 4 times.

Verification (IMG_W=8, IMG_H=6, DSIZE=5)
REQ-035 Ramp frame, each channel = (8y+x) mod 32 -> first o_win_valid after the 37th accept; window idx0=(0,0) value 0, idx24=(4,4) value 4; 8 windows total.
REQ-036 Constant frame, pixel 0x4210, through the blur datapath -> every o_blur_valid output = 0x4210; first o_x=2, o_y=2.
REQ-037 i_valid high every other cycle -> same 8 windows as REQ-035; o_win_valid never high on gap cycles.
REQ-038 Reset asserted after 20 accepts -> o_ready=0, o_busy=0 immediately; the next frame reproduces REQ-035 exactly.
REQ-039 i_start pulsed mid-RUN -> no effect; o_done high exactly one cycle at T+3; o_busy drops the same cycle o_done falls.
